tt_ifft4_stream: RTL

TT_IFFT4_STREAM -- requirements
Module: tt_ifft4_stream

---
 rtl/tt_ifft4_stream_if.sv | 21 ++
 rtl/tt_ifft4_stream.sv | 99 +++++++++
 2 files changed

// File: rtl/tt_ifft4_stream_if.sv
// Stream bundle for the 4-point IFFT: byte-serial spectrum in, byte-serial time samples out.
interface tt_ifft4_stream_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, frame_done
  );
endinterface

// File: rtl/tt_ifft4_stream.sv
// 4-point radix-2 IFFT over a byte stream: load 8 components, two butterfly stages,
// then drain 8 scaled (>>>2, floor) components with backpressure.
module tt_ifft4_stream #(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  tt_ifft4_stream_if.slave   bus
);
  localparam int SW = DATA_W + 1;
  localparam int RW = DATA_W + 2;

  typedef enum logic [1:0] {LOAD, COMP1, COMP2, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                iidx, oidx;
  logic signed [DATA_W-1:0]  xr [4];
  logic signed [DATA_W-1:0]  xi [4];
  logic signed [SW-1:0]      ar, ai, br, bi, cr, ci, dr, di;
  logic signed [RW-1:0]      sum [8];
  logic [DATA_W-1:0]         y [8];
  logic                      frame_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.busy       = 1'b1;
    bus.frame_done = frame_done_q;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid && iidx == 3'd7) state_nxt = COMP1;
      end
      COMP1: state_nxt = COMP2;
      COMP2: state_nxt = DRAIN;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = y[oidx];
        if (bus.out_ready && oidx == 3'd7) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Second-stage sums in output order re0, im0, re1, im1, ...; full width so nothing wraps.
  always_comb begin
    sum[0] = RW'(ar) + RW'(cr);
    sum[1] = RW'(ai) + RW'(ci);
    sum[2] = RW'(br) - RW'(di);
    sum[3] = RW'(bi) + RW'(dr);
    sum[4] = RW'(ar) - RW'(cr);
    sum[5] = RW'(ai) - RW'(ci);
    sum[6] = RW'(br) + RW'(di);
    sum[7] = RW'(bi) - RW'(dr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iidx         <= '0;
      oidx         <= '0;
      frame_done_q <= 1'b0;
      {ar, ai, br, bi, cr, ci, dr, di} <= '0;
      for (int k = 0; k < 4; k++) begin
        xr[k] <= '0;
        xi[k] <= '0;
      end
      for (int k = 0; k < 8; k++) y[k] <= '0;
    end else begin
      frame_done_q <= (state == DRAIN) && bus.out_ready && (oidx == 3'd7);
      if (state == LOAD && bus.in_valid) begin
        if (iidx[0]) xi[iidx[2:1]] <= bus.in_data;
        else         xr[iidx[2:1]] <= bus.in_data;
        iidx <= iidx + 3'd1;
      end
      if (state == COMP1) begin
        ar <= SW'(xr[0]) + SW'(xr[2]);
        ai <= SW'(xi[0]) + SW'(xi[2]);
        br <= SW'(xr[0]) - SW'(xr[2]);
        bi <= SW'(xi[0]) - SW'(xi[2]);
        cr <= SW'(xr[1]) + SW'(xr[3]);
        ci <= SW'(xi[1]) + SW'(xi[3]);
        dr <= SW'(xr[1]) - SW'(xr[3]);
        di <= SW'(xi[1]) - SW'(xi[3]);
      end
      // Dropping the two LSBs of a signed sum is the floor of /4.
      if (state == COMP2)
        for (int k = 0; k < 8; k++) y[k] <= sum[k][RW-1:2];
      if (state == DRAIN && bus.out_ready) oidx <= oidx + 3'd1;
    end
  end
endmodule
